// File: rtl/gf_pkg.sv
// Shared types and constants for the GF(2^W) reduction blocks.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } gf_state_e;

    localparam int unsigned GF_W        = 8;
    localparam logic [8:0]  GF_POLY_AES = 9'h11B;
    localparam logic [2:0]  GF_POLY_GF4 = 3'b111;

endpackage

// File: rtl/gf_reduce_step.sv
// One bit-serial reduction step: clears product bit W+cnt by XORing in POLY<<cnt when that bit is set.
module gf_reduce_step
    import gf_pkg::*;
#(
    parameter int unsigned W    = GF_W,
    parameter logic [W:0]  POLY = (W+1)'(GF_POLY_AES),
    parameter int unsigned CW   = 3
) (
    input  logic [2*W-2:0] acc,
    input  logic [CW-1:0]  cnt,
    output logic [2*W-2:0] acc_out
);

    localparam int unsigned AW = 2*W - 1;

    logic [AW-1:0] poly_ext;
    logic [AW-1:0] bit_sel;
    logic          lead_set;

    assign poly_ext = AW'(POLY);
    assign bit_sel  = (AW'(1) << W) << cnt;
    assign lead_set = |(acc & bit_sel);
    assign acc_out  = lead_set ? (acc ^ (poly_ext << cnt)) : acc;

endmodule

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^W) reducer: reduces a 2W-1-bit carry-less product mod POLY, one bit per cycle.
// Optional `GF_REDUCE_EARLY_EXIT_EN finishes as soon as no product bits at or above x^W remain.
module gf_reduce_seq
    import gf_pkg::*;
#(
    parameter int unsigned W    = GF_W,
    parameter logic [W:0]  POLY = (W+1)'(GF_POLY_AES)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-2:0] in_prod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_rem,
    output logic           busy
);

    localparam int unsigned AW = 2*W - 1;
    localparam int unsigned CW = (W > 2) ? $clog2(W-1) : 1;

    if (W < 2) begin : g_bad_width
        $error("gf_reduce_seq: W must be at least 2");
    end
    if (POLY[W] != 1'b1) begin : g_bad_poly
        $error("gf_reduce_seq: POLY bit W must be set");
    end

    gf_state_e     state, state_nxt;
    logic [AW-1:0] acc, acc_nxt, step_acc;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          out_valid_nxt;
    logic [W-1:0]  out_rem_nxt;
    logic          busy_nxt;

    gf_reduce_step #(
        .W    (W),
        .POLY (POLY),
        .CW   (CW)
    ) u_step (
        .acc     (acc),
        .cnt     (cnt),
        .acc_out (step_acc)
    );

    // Deliberate combinational path out_ready -> in_ready for back-to-back acceptance.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_rem   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= out_valid_nxt;
            out_rem   <= out_rem_nxt;
            busy      <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        out_valid_nxt = 1'b0;
        out_rem_nxt   = out_rem;
        busy_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nxt   = in_prod;
                    cnt_nxt   = CW'(W-2);
                    state_nxt = REDUCE;
                end
            end
            REDUCE: begin
`ifdef GF_REDUCE_EARLY_EXIT_EN
                // Bits above the one being cleared are already zero, so this covers every unprocessed bit.
                if (~|acc[AW-1:W]) begin
                    state_nxt = DONE;
                end else begin
                    acc_nxt = step_acc;
                    if (cnt == '0) begin
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
`else
                acc_nxt = step_acc;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        acc_nxt   = in_prod;
                        cnt_nxt   = CW'(W-2);
                        state_nxt = REDUCE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Registered outputs track the state being entered.
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt == REDUCE);
        if (state_nxt == DONE) begin
            out_rem_nxt = acc_nxt[W-1:0];
        end
    end

endmodule

// File: tb/tb_gf_reduce_seq.sv
// Directed-vector and soak bench for gf_reduce_seq at W=8 (AES polynomial) and W=2 (GF(4)).
module tb_gf_reduce_seq;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [14:0] in_prod8;
    logic [7:0]  out_rem8;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [2:0]  in_prod2;
    logic [1:0]  out_rem2;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gf_reduce_seq #(.W(8), .POLY(9'h11B)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_prod   (in_prod8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_rem   (out_rem8),
        .busy      (busy8)
    );

    gf_reduce_seq #(.W(2), .POLY(3'b111)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_prod   (in_prod2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_rem   (out_rem2),
        .busy      (busy2)
    );

    typedef struct {
        logic [14:0] prod;
        logic [7:0]  rem;
    } vec8_t;

    typedef struct {
        logic [2:0] prod;
        logic [1:0] rem;
    } vec2_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Bit-serial reference: clear x^14 .. x^8 from the top down.
    function automatic logic [7:0] ref_reduce(input logic [14:0] p);
        logic [14:0] a;
        logic [14:0] poly;
        a    = p;
        poly = 15'h011B;
        for (int i = 14; i >= 8; i--) begin
            if (a[i]) a = a ^ (poly << (i - 8));
        end
        return a[7:0];
    endfunction

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic check_lat8(input string nm, input int lat);
`ifdef GF_REDUCE_EARLY_EXIT_EN
        check(nm, 32'((lat >= 1) && (lat <= 7)), 32'd1);
`else
        check(nm, 32'(lat), 32'd7);
`endif
    endtask

    task automatic run8(input logic [14:0] p, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        in_valid8  = 1'b1;
        in_prod8   = p;
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        wait_done8(lat);
        check("w8_valid", 32'(out_valid8), 32'd1);
        check("w8_rem", 32'(out_rem8), 32'(exp));
        check_lat8("w8_latency", lat);
    endtask

    task automatic run2(input logic [2:0] p, input logic [1:0] exp);
        int lat;
        @(negedge clk);
        in_valid2  = 1'b1;
        in_prod2   = p;
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("w2_valid", 32'(out_valid2), 32'd1);
        check("w2_rem", 32'(out_rem2), 32'(exp));
        check("w2_latency", 32'(lat), 32'd1);
    endtask

    initial begin
        vec8_t v8 [8];
        vec2_t v2 [4];
        int    lat;
        bit    seen;
        int    sent, recv;
        bit    acc_prev;
        logic [7:0] q [$];

        v8[0] = '{15'h2B79, 8'hC1};
        v8[1] = '{15'h0100, 8'h1B};
        v8[2] = '{15'h00FF, 8'hFF};
        v8[3] = '{15'h0000, 8'h00};
        v8[4] = '{15'h4000, 8'h9A};
        v8[5] = '{15'h7FFF, 8'h1A};
        v8[6] = '{15'h0200, 8'h36};
        v8[7] = '{15'h010E, 8'h15};
        v2[0] = '{3'b100, 2'b11};
        v2[1] = '{3'b101, 2'b10};
        v2[2] = '{3'b011, 2'b11};
        v2[3] = '{3'b110, 2'b01};

        rst_n      = 1'b0;
        in_valid8  = 1'b0;
        in_prod8   = '0;
        out_ready8 = 1'b1;
        in_valid2  = 1'b0;
        in_prod2   = '0;
        out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_out_rem", 32'(out_rem8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_in_ready_w2", 32'(in_ready2), 32'd1);

        foreach (v8[i]) run8(v8[i].prod, v8[i].rem);
        foreach (v2[i]) run2(v2[i].prod, v2[i].rem);

        // Backpressure in DONE, then back-to-back acceptance on the releasing edge.
        @(negedge clk);
        in_valid8  = 1'b1;
        in_prod8   = 15'h2B79;
        out_ready8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        wait_done8(lat);
        check_lat8("bp_latency", lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid8), 32'd1);
            check("bp_rem", 32'(out_rem8), 32'hC1);
            check("bp_in_ready", 32'(in_ready8), 32'd0);
        end
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in_prod8   = 15'h0100;
        #1;
        check("b2b_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        check("b2b_valid_drop", 32'(out_valid8), 32'd0);
        check("b2b_busy", 32'(busy8), 32'd1);
        wait_done8(lat);
        check("b2b_rem", 32'(out_rem8), 32'h1B);
        check("b2b_latency", 32'(lat), 32'd7);

        // Reset while REDUCE is at cnt=3: the product is dropped.
        @(negedge clk);
        in_valid8 = 1'b1;
        in_prod8  = 15'h7FFF;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifndef GF_REDUCE_EARLY_EXIT_EN
        check("mid_busy", 32'(busy8), 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid8), 32'd0);
        check("mid_rst_rem", 32'(out_rem8), 32'd0);
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | out_valid8;
        end
        check("mid_no_output", 32'(seen), 32'd0);
        check("mid_in_ready_after", 32'(in_ready8), 32'd1);

        // Random soak with random backpressure against the reference model.
        sent     = 0;
        recv     = 0;
        acc_prev = 1'b0;
        for (int cyc = 0; cyc < 30000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (acc_prev) in_valid8 = 1'b0;
            if (!in_valid8 && sent < 1000) begin
                in_valid8 = ($urandom_range(0, 3) != 0);
                in_prod8  = 15'($urandom);
            end
            out_ready8 = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid8 && out_ready8) begin
                if (q.size() == 0) begin
                    check("soak_extra_result", 32'd1, 32'd0);
                end else begin
                    check("soak_rem", 32'(out_rem8), 32'(q.pop_front()));
                    recv++;
                end
            end
            acc_prev = in_valid8 && in_ready8;
            if (acc_prev) begin
                q.push_back(ref_reduce(in_prod8));
                sent++;
            end
        end
        check("soak_count", 32'(recv), 32'd1000);
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
